pulpino_gpio_xfer_ctrl: RTL
===========================

// Module: pulpino_gpio_xfer_ctrl
// PURPOSE
//  Sequences 32-bit word transfers between the USB register side and the PULPino core.
//  Uses the 8-bit GPIO byte lanes and a toggle handshake.
//  Replaces ad-hoc turn bookkeeping: TX (USB->PULPino) and RX (PULPino->USB) engines
//  run concurrently, with per-byte timeouts and a sticky error flag.
//  Sits in the pulpino_clk domain between the register block and the PULPino GPIO pins.
// PARAMETERS
//  pTIMEOUT    default 4096   max cycles waiting on one byte handshake; 0 disables timeouts
//  pCNT_WIDTH  default 16     width of the timeout counter; must satisfy pTIMEOUT < 2**pCNT_WIDTH
// PORTS
//  clk            in   1   pulpino_clk; the only clock
//  resetn         in   1   asynchronous, active-low reset
//  tx_word        in   32  word to send to PULPino; byte 0 = tx_word[7:0]
//  tx_valid       in   1   tx_word valid
//  tx_ready       out  1   TX engine idle; accept occurs when tx_valid & tx_ready
//  rx_word        out  32  word received from PULPino; byte 0 = rx_word[7:0]
//  rx_valid       out  1   rx_word complete; held until rx_ready
//  rx_ready       in   1   consumer takes rx_word when rx_valid & rx_ready
//  gpio_data_in   out  8   byte driven onto PULPino GPIO inputs
//  io_turn        out  1   toggles when a new TX byte is presented
//  pulpino_ack    in   1   PULPino echo of io_turn; equal means the byte is taken
//  gpio_data_out  in   8   byte driven by PULPino GPIO outputs
//  pulpino_turn   in   1   PULPino toggles it when a new RX byte is presented
//  io_ack         out  1   echo of pulpino_turn; equal means the byte is taken
//  clear_err      in   1   one-cycle pulse; clears err_timeout
//  err_timeout    out  1   sticky: a handshake timed out and a transfer was aborted
//  busy           out  1   TX or RX engine mid-word
// BEHAVIOUR
//  Reset values (all registered): gpio_data_in=0, io_turn=0, io_ack=0, rx_word=0,
//    rx_valid=0, err_timeout=0; TX=TX_IDLE, RX=RX_IDLE, byte indices=0, counters=0.
//  Derived outputs: tx_ready=(TX==TX_IDLE); busy=(TX!=TX_IDLE)|(RX==RX_RECV).
//  TX FSM: TX_IDLE -> TX_WAIT -> TX_IDLE.
//  - Accept in TX_IDLE latches tx_word.
//    Next edge: gpio_data_in=byte0, io_turn toggles, tx_idx=0, TX_WAIT, tcnt=0.
//  - TX_WAIT, pulpino_ack==io_turn, tx_idx<3: next edge presents byte tx_idx+1 and
//    toggles io_turn, tcnt=0.
//  - TX_WAIT, pulpino_ack==io_turn, tx_idx==3: -> TX_IDLE; tx_ready high next cycle.
//    Word latency = 4 acks + 1 cycle.
//  - TX_WAIT, no ack, tcnt==pTIMEOUT-1 (pTIMEOUT!=0): abort -> TX_IDLE.
//    io_turn := pulpino_ack so the lane is quiescent; err_timeout:=1; rest of word dropped.
//  RX FSM: RX_IDLE -> RX_RECV -> RX_FULL -> RX_IDLE.
//  - Byte pending = (pulpino_turn != io_ack) and RX != RX_FULL.
//  - Pending byte: capture gpio_data_out into rx_word[8*rx_idx+:8] and toggle io_ack
//    on the same edge (1-cycle ack latency). rx_idx increments; RX_IDLE -> RX_RECV on byte 0.
//  - Capture with rx_idx==3: -> RX_FULL, rx_valid=1 next cycle, rx_idx=0.
//  - RX_FULL: no acks (PULPino is back-pressured) until rx_valid & rx_ready.
//    Then rx_valid=0 and -> RX_IDLE on that edge.
//  - RX_RECV timeout: no byte for pTIMEOUT cycles -> drop partial word, rx_idx=0,
//    -> RX_IDLE, err_timeout:=1. RX_IDLE and RX_FULL never time out.
//  Counters saturate and never wrap. TX and RX are fully independent; both may step on
//    the same cycle.
//  err_timeout: set has priority over clear_err on the same cycle.
//  tx_valid while TX busy: ignored and held off by tx_ready=0; no overwrite of the latched word.
//  resetn assertion mid-word: immediate async return to reset values; partial words are lost.
// TESTING
//  1. Send tx_word=32'hA1B2C3D4 with a responder acking after 3 cycles.
//     -> gpio_data_in sequence D4,C3,B2,A1; io_turn toggles 4x; tx_ready returns 1
//     one cycle after the 4th ack; err_timeout stays 0.
//  2. PULPino sends 11,22,33,44 with rx_ready=1.
//     -> rx_word=32'h44332211 with a single rx_valid pulse; io_ack toggles 4x,
//     each 1 cycle after the pulpino_turn toggle.
//  3. Hold rx_ready=0 and send 8 bytes.
//     -> after byte 4, io_ack freezes and byte 5 is not acked until rx_ready=1;
//     the second word is 32'h88776655.
//  4. pTIMEOUT=16, responder silent after byte 1.
//     -> abort exactly 16 cycles after byte 1 is presented; err_timeout=1,
//     io_turn==pulpino_ack, tx_ready=1. clear_err pulse -> err_timeout=0.
//  5. Concurrent TX and RX words, plus clear_err in the same cycle as a timeout.
//     -> both words correct; err_timeout=1 (set wins).
//  6. Drop resetn during the byte-2 handshake in both directions.
//     -> all outputs reach reset values asynchronously; a fresh word after release
//     transfers correctly.

Source files
------------

// File: rtl/pulpino_gpio_xfer_ctrl.sv
// 32-bit word transfer sequencer over the PULPino 8-bit GPIO lanes.
// Ports: tx/rx word handshakes, GPIO byte lanes + toggle turn/ack, clear_err/err_timeout, busy.
module pulpino_gpio_xfer_ctrl #(
  parameter int unsigned pTIMEOUT   = 4096,
  parameter int unsigned pCNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_word,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  gpio_data_in,
  output logic        io_turn,
  input  logic        pulpino_ack,
  input  logic [7:0]  gpio_data_out,
  input  logic        pulpino_turn,
  output logic        io_ack,
  input  logic        clear_err,
  output logic        err_timeout,
  output logic        busy
);

  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_FULL} rx_state_t;

  localparam bit TMO_EN = (pTIMEOUT != 0);
  localparam logic [pCNT_WIDTH-1:0] TMO_LAST =
    pCNT_WIDTH'(pTIMEOUT - 1);

  tx_state_t             tx_state;
  rx_state_t             rx_state;
  logic [31:0]           tx_lat;
  logic [1:0]            tx_idx;
  logic [1:0]            rx_idx;
  logic [pCNT_WIDTH-1:0] tcnt;
  logic [pCNT_WIDTH-1:0] rcnt;

  logic tx_ack;
  logic tx_tmo;
  logic rx_pend;
  logic rx_take;
  logic rx_tmo;

  assign tx_ready = (tx_state == TX_IDLE);
  assign busy     = (tx_state != TX_IDLE) |
                    (rx_state == RX_RECV);

  assign tx_ack  = (tx_state == TX_WAIT) &&
                   (pulpino_ack == io_turn);
  assign tx_tmo  = TMO_EN && (tx_state == TX_WAIT) &&
                   !tx_ack && (tcnt == TMO_LAST);
  // A full word back-pressures PULPino by withholding the ack.
  assign rx_pend = (pulpino_turn != io_ack) &&
                   (rx_state != RX_FULL);
  assign rx_take = (rx_state == RX_FULL) &&
                   rx_valid && rx_ready;
  assign rx_tmo  = TMO_EN && (rx_state == RX_RECV) &&
                   !rx_pend && (rcnt == TMO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state     <= TX_IDLE;
      tx_lat       <= '0;
      tx_idx       <= '0;
      tcnt         <= '0;
      gpio_data_in <= '0;
      io_turn      <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid) begin
            tx_lat       <= tx_word;
            gpio_data_in <= tx_word[7:0];
            io_turn      <= ~io_turn;
            tx_idx       <= '0;
            tcnt         <= '0;
            tx_state     <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_ack) begin
            if (tx_idx == 2'd3) begin
              tx_state <= TX_IDLE;
            end else begin
              gpio_data_in <=
                tx_lat[{tx_idx + 2'd1, 3'b000} +: 8];
              io_turn <= ~io_turn;
              tx_idx  <= tx_idx + 2'd1;
              tcnt    <= '0;
            end
          end else if (tx_tmo) begin
            // Match the ack so the lane looks idle to PULPino.
            io_turn  <= pulpino_ack;
            tx_state <= TX_IDLE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state <= RX_IDLE;
      rx_idx   <= '0;
      rcnt     <= '0;
      rx_word  <= '0;
      rx_valid <= 1'b0;
      io_ack   <= 1'b0;
    end else begin
      unique case (1'b1)
        rx_pend: begin
          rx_word[{rx_idx, 3'b000} +: 8] <= gpio_data_out;
          io_ack <= ~io_ack;
          rcnt   <= '0;
          if (rx_idx == 2'd3) begin
            rx_state <= RX_FULL;
            rx_valid <= 1'b1;
            rx_idx   <= '0;
          end else begin
            rx_state <= RX_RECV;
            rx_idx   <= rx_idx + 2'd1;
          end
        end
        rx_take: begin
          rx_valid <= 1'b0;
          rx_state <= RX_IDLE;
        end
        rx_tmo: begin
          rx_state <= RX_IDLE;
          rx_idx   <= '0;
          rcnt     <= '0;
        end
        default: begin
          if (rx_state == RX_RECV && rcnt != '1)
            rcnt <= rcnt + 1'b1;
        end
      endcase
    end
  end

  // A new timeout wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      err_timeout <= 1'b0;
    else if (tx_tmo || rx_tmo)
      err_timeout <= 1'b1;
    else if (clear_err)
      err_timeout <= 1'b0;
  end

endmodule
